// File: rtl/pingpong_ctrl.sv
// Ping-pong buffer sequencer: fills one 256-byte half of a 512-byte dual-port
// buffer from a byte stream and drains the other half over valid/ready.
module pingpong_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       flush,
  output logic       we,
  output logic [8:0] write_addr,
  output logic [7:0] din,
  output logic [7:0] read_addr,
  input  logic [7:0] dout,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       blk_start,
  output logic [8:0] blk_len,
  output logic       blk_done,
  output logic       overflow,
  output logic [15:0] drop_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD} rd_state_t;

  rd_state_t   r_state;
  rd_state_t   w_state_nxt;

  logic [8:0]  r_wr_cnt;
  logic        r_flush_pend;
  logic        r_drain_req;
  logic        r_we;
  logic [8:0]  r_write_addr;
  logic [7:0]  r_din;
  logic [8:0]  r_blk_len;
  logic        r_overflow;
  logic [15:0] r_drop_cnt;

  logic [7:0]  r_read_addr;
  logic        r_out_valid;
  logic [7:0]  r_out_data;
  logic        r_blk_start;
  logic        r_blk_done;

  logic        w_full;
  logic        w_swap;
  logic        w_accept;
  logic        w_drop;
  logic        w_last;
  logic [7:0]  w_read_addr_nxt;
  logic        w_out_valid_nxt;
  logic [7:0]  w_out_data_nxt;
  logic        w_blk_start_nxt;
  logic        w_blk_done_nxt;
  logic        w_req_clr;

  // The write bank is carried in write_addr[8]; the reader always uses its inverse,
  // so the swap is only allowed while the reader is idle with no drain queued.
  assign w_full   = r_wr_cnt[8];
  assign w_swap   = (r_state == S_IDLE) && !r_drain_req &&
                    (w_full || (r_flush_pend && (r_wr_cnt != 9'd0)));
  assign w_accept = in_valid && !w_full && !w_swap;
  assign w_drop   = in_valid && !w_accept;
  assign w_last   = ({1'b0, r_read_addr} == (r_blk_len - 9'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_cnt     <= '0;
      r_flush_pend <= 1'b0;
      r_drain_req  <= 1'b0;
      r_we         <= 1'b0;
      r_write_addr <= '0;
      r_din        <= '0;
      r_blk_len    <= '0;
      r_overflow   <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_we <= w_accept;
      if (w_accept) begin
        r_write_addr <= {r_write_addr[8], r_wr_cnt[7:0]};
        r_din        <= in_data;
        r_wr_cnt     <= r_wr_cnt + 9'd1;
      end else if (w_swap) begin
        r_write_addr <= {~r_write_addr[8], 8'h00};
        r_wr_cnt     <= '0;
        r_blk_len    <= r_wr_cnt;
      end

      // A flush in the same cycle as an accepted byte still closes that byte's block.
      if (w_swap)
        r_flush_pend <= 1'b0;
      else if (flush && ((r_wr_cnt != 9'd0) || w_accept))
        r_flush_pend <= 1'b1;

      if (w_swap)
        r_drain_req <= 1'b1;
      else if (w_req_clr)
        r_drain_req <= 1'b0;

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF)
          r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_read_addr <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_blk_start <= 1'b0;
      r_blk_done  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_read_addr <= w_read_addr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_blk_start <= w_blk_start_nxt;
      r_blk_done  <= w_blk_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_read_addr_nxt = r_read_addr;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_blk_start_nxt = 1'b0;
    w_blk_done_nxt  = 1'b0;
    w_req_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_drain_req) begin
          w_state_nxt     = S_FETCH;
          w_read_addr_nxt = 8'h00;
          w_blk_start_nxt = 1'b1;
          w_req_clr       = 1'b1;
        end
      end
      S_FETCH: w_state_nxt = S_LOAD;
      S_LOAD: begin
        w_out_data_nxt  = dout;
        w_out_valid_nxt = 1'b1;
        w_state_nxt     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (w_last) begin
            w_state_nxt    = S_IDLE;
            w_blk_done_nxt = 1'b1;
          end else begin
            w_read_addr_nxt = r_read_addr + 8'd1;
            w_state_nxt     = S_FETCH;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign we         = r_we;
  assign write_addr = r_write_addr;
  assign din        = r_din;
  assign read_addr  = r_read_addr;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign blk_start  = r_blk_start;
  assign blk_len    = r_blk_len;
  assign blk_done   = r_blk_done;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_pingpong_ctrl.sv
// Directed bench for pingpong_ctrl with a 512-byte buffer model and
// write/drain scoreboards.
module tb_pingpong_ctrl;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush, out_ready;
  logic [7:0] in_data, dout, din, read_addr, out_data;
  logic       we, out_valid, blk_start, blk_done, overflow;
  logic [8:0] write_addr, blk_len;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  pingpong_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .we(we), .write_addr(write_addr), .din(din), .read_addr(read_addr), .dout(dout),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .blk_start(blk_start), .blk_len(blk_len), .blk_done(blk_done),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  logic [7:0] mem [0:511];
  always @(posedge clk) begin
    if (we) mem[write_addr] <= din;
    dout <= mem[{~write_addr[8], read_addr}];
  end

  int n_pass = 0;
  int n_total = 0;
  int n_done = 0;
  int n_start = 0;
  int mode = 0;
  logic       m_bank = 1'b0;
  logic [8:0] m_cnt = '0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  logic [16:0] wq[$];
  logic [7:0]  dq[$];
  logic [8:0]  lq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    if (m_cnt < 9'd256) begin
      wq.push_back({m_bank, m_cnt[7:0], d});
      dq.push_back(d);
      m_cnt++;
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic model_swap(input logic [8:0] len);
    lq.push_back(len);
    m_bank = ~m_bank;
    m_cnt  = '0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_drain(input int target, input int budget);
    int k = 0;
    while ((n_done < target || dq.size() != 0) && k < budget) begin
      step();
      k++;
    end
    check("drain_done_cnt", n_done, target);
    check("drain_queue_empty", dq.size(), 0);
  endtask

  task automatic check_reset_state();
    check("rst_we", we, 0);
    check("rst_write_addr", write_addr, 0);
    check("rst_din", din, 0);
    check("rst_read_addr", read_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_blk_start", blk_start, 0);
    check("rst_blk_len", blk_len, 0);
    check("rst_blk_done", blk_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wq.delete();
    dq.delete();
    lq.delete();
    m_bank = 1'b0;
    m_cnt  = '0;
    step();
    check_reset_state();
    rst = 1'b0;
  endtask

  // Scoreboard side: writes, drained bytes, block starts and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, prev_data);
      end
      if (we) begin
        check("write_expected", 32'(wq.size() > 0), 1);
        if (wq.size() > 0) check("write_addr_data", {write_addr, din}, wq.pop_front());
      end
      if (out_valid && out_ready) begin
        check("byte_expected", 32'(dq.size() > 0), 1);
        if (dq.size() > 0) check("out_data", out_data, dq.pop_front());
      end
      if (blk_start) begin
        check("start_expected", 32'(lq.size() > 0), 1);
        if (lq.size() > 0) check("blk_len", blk_len, lq.pop_front());
        n_start <= n_start + 1;
      end
      if (blk_done) n_done <= n_done + 1;
      prev_stall <= out_valid && !out_ready;
      prev_data  <= out_data;
    end
  end

  initial begin
    int base;
    int k;
    int lens [3];
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b1;
    step();
    do_reset();

    // Full half 0x00..0xFF, free-running consumer
    for (int i = 0; i < 256; i++) send(8'(i));
    model_swap(9'd256);
    wait_drain(1, 2000);
    check("t1_overflow", overflow, 0);
    check("t1_wq_empty", wq.size(), 0);
    check("t1_write_addr", write_addr, {m_bank, 8'h00});

    // Ten bytes then flush, from reset
    do_reset();
    base = n_done;
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)));
    step();
    do_flush();
    model_swap(9'd10);
    wait_drain(base + 1, 200);
    check("t2_write_addr", write_addr, 9'h100);

    // Flush with nothing buffered
    base = n_start;
    do_flush();
    for (int i = 0; i < 10; i++) step();
    check("t3_no_start", n_start, base);
    check("t3_write_addr", write_addr, 9'h100);

    // Stalled drain while the other half overfills
    mode = 1;
    base = n_done;
    for (int i = 0; i < 20; i++) send(8'(8'hA0 + i));
    step();
    do_flush();
    model_swap(9'd20);
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 260; i++) send(8'(i * 3));
    step();
    step();
    check("t4_overflow", overflow, 1);
    check("t4_drop_cnt", drop_cnt, 4);
    model_swap(9'd256);
    mode = 0;
    wait_drain(base + 2, 3000);
    step();
    check("t4_write_addr", write_addr, {m_bank, 8'h00});

    // Three blocks with random consumer stalls
    mode = 2;
    lens[0] = 256; lens[1] = 37; lens[2] = 200;
    for (int b = 0; b < 3; b++) begin
      base = n_done;
      for (int i = 0; i < lens[b]; i++) send(8'($urandom_range(0, 255)));
      if (lens[b] < 256) begin
        step();
        do_flush();
      end
      model_swap(9'(lens[b]));
      wait_drain(base + 1, 4000);
    end

    // Reset while holding byte 100 of a drain
    mode = 0;
    for (int i = 0; i < 256; i++) send(8'(i ^ 8'h5A));
    model_swap(9'd256);
    k = 0;
    while (!(out_valid && read_addr == 8'd100) && k < 2000) begin
      step();
      k++;
    end
    check("t6_reached_hold_100", {31'b0, out_valid}, 1);
    mode = 1;
    out_ready = 1'b0;
    base = n_done;
    do_reset();
    for (int i = 0; i < 8; i++) step();
    check("t6_no_blk_done", n_done, base);
    mode = 0;
    for (int i = 0; i < 256; i++) send(8'(255 - i));
    model_swap(9'd256);
    wait_drain(base + 1, 2000);
    check("t6_write_addr", write_addr, 9'h100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
